pseudo_rand_check: RTL
======================

PSEUDO_RAND_CHECK -- requirements
Module: pseudo_rand_check

Interface
REQ-001 Parameter WIDTH, default 32: observed sample width, 1..257.
REQ-002 Parameter LOCK_CNT, default 8: consecutive matches needed to declare lock, 1..255.
REQ-003 Parameter LOST_CNT, default 4: consecutive mismatches while locked that declare loss, 1..255.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 in_valid  input  1  in_data carries a sample this cycle.
REQ-008 in_data  input  WIDTH  sample from a pseudo_rand generator of equal WIDTH.
REQ-009 resync  input  1  single-cycle request to restart the hunt.
REQ-010 locked  output  1  the checker is tracking the stream.
REQ-011 lost  output  1  sticky; lock was lost.
REQ-012 err  output  1  single-cycle pulse per mismatching sample while locked.
REQ-013 err_count  output  16  saturating count of mismatches while locked.
REQ-014 match_count  output  32  saturating count of matching samples in LOCKING or LOCKED.

Function
REQ-015 The block SHALL hold an expected LFSR state exp of LFSR_WIDTH bits: 64 for WIDTH<=64, 128 for WIDTH<=128, 257 otherwise.
REQ-016 The next state SHALL be {exp[LFSR_WIDTH-2:0],1'b0} XOR (replicated exp[LFSR_WIDTH-1] AND POLY), with POLY low byte 8'b00011011, 8'b10000111 or 8'b11000101 for widths 64, 128 and 257.
REQ-017 A sample SHALL match when in_data equals exp[WIDTH-1:0].
REQ-018 exp SHALL advance only on in_valid cycles, and only in the cases named below.
REQ-019 State HUNT: exp = SEED; a valid match advances exp, sets run=1 and goes to LOCKING (or LOCKED if LOCK_CNT=1); a valid mismatch holds exp.
REQ-020 State LOCKING: a valid match advances exp and increments run; when run reaches LOCK_CNT, go to LOCKED.
REQ-021 State LOCKING: a valid mismatch reloads exp=SEED and returns to HUNT; the mismatching sample is not re-compared.
REQ-022 State LOCKED: every valid sample advances exp.
REQ-023 State LOCKED: a mismatch pulses err next cycle, increments err_count and increments the consecutive-miss counter; a match clears the miss counter.
REQ-024 When the miss counter reaches LOST_CNT, the block SHALL set lost, go to HUNT and reload exp=SEED.
REQ-025 State LOST_HOLD does not exist; lost stays set through HUNT/LOCKING/LOCKED until resync or reset.
REQ-026 locked SHALL be 1 exactly when the state is LOCKED.
REQ-027 All outputs SHALL be registered; err, the counters and locked reflect a sample one cycle after it is presented.
REQ-028 err_count SHALL saturate at 16'hFFFF and match_count at 32'hFFFF_FFFF; saturated counters do not wrap.
REQ-029 resync SHALL have priority over in_valid in the same cycle: state HUNT, exp=SEED, lost=0, run and miss cleared, counters cleared, sample ignored.
REQ-030 in_valid low SHALL leave all state unchanged; gaps never count as mismatches.

Reset
REQ-031 While reset is low, the block SHALL set state=HUNT and exp=SEED.
REQ-032 While reset is low: locked=0, lost=0, err=0, err_count=0, match_count=0, and run and miss counters 0.
REQ-033 Reset assertion mid-lock SHALL take effect asynchronously; deassertion is synchronized by the integrator.

Structure
REQ-034 Package pseudo_rand_pkg SHALL hold the 257-bit SEED, the LFSR_WIDTH selection function, the POLY selection function and the state enum {HUNT, LOCKING, LOCKED}.
REQ-035 Sub-module pseudo_rand_step SHALL compute the combinational LFSR next state (parameter LFSR_WIDTH) so the generator and checker share it.

Verification
REQ-036 Scenario, in-sync lock: WIDTH=32, samples 32'h04e4684a then 32'h09c8d094, continued from a generator -> locked rises one cycle after the 8th match; err never pulses.
REQ-037 Scenario, late generator: 5 valid samples of 0, then a correct stream -> remains in HUNT for those 5 samples, then locks after 8 matches; err_count=0.
REQ-038 Scenario, single corruption while locked: flip bit 0 of one sample -> err pulses once, err_count=1, locked stays 1, next correct sample matches.
REQ-039 Scenario, loss of lock: 4 consecutive corrupted samples while locked -> lost=1, locked=0, err_count=4, then relock with lost still 1.
REQ-040 Scenario, resync with in_valid and a mismatching sample in the same cycle -> lost=0, counters 0, state HUNT, sample ignored.
REQ-041 Scenario, 3-cycle in_valid gaps within a locked stream -> no err, match_count counts only valid samples.

Source files
------------

// File: rtl/pseudo_rand_pkg.sv
// Shared constants and helpers for the pseudo-random generator/checker pair:
// seed, LFSR width selection, feedback polynomial and checker state encoding.
package pseudo_rand_pkg;

  localparam logic [256:0] SEED =
    257'h1f2e3d4c_5b6a7988_97a6b5c4_d3e2f100_8badf00d_deadbeef_3afef00d_04e4684a;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    LOCKING = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  // Narrowest supported register that still covers the observed sample width.
  function automatic int lfsr_width(input int width);
    if (width <= 64) begin
      return 64;
    end else if (width <= 128) begin
      return 128;
    end else begin
      return 257;
    end
  endfunction

  // Only the low byte of each feedback polynomial is non-zero.
  function automatic logic [256:0] lfsr_poly(input int lw);
    logic [256:0] p;
    p = '0;
    case (lw)
      64:      p[7:0] = 8'b0001_1011;
      128:     p[7:0] = 8'b1000_0111;
      default: p[7:0] = 8'b1100_0101;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/pseudo_rand_check_if.sv
// Sample stream in, lock status and statistics out, between a stream source
// (master) and the checker (slave).
interface pseudo_rand_check_if #(
  parameter int WIDTH = 32
) ();

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             resync;
  logic             locked;
  logic             lost;
  logic             err;
  logic [15:0]      err_count;
  logic [31:0]      match_count;

  modport master (
    output in_valid, in_data, resync,
    input  locked, lost, err, err_count, match_count
  );

  modport slave (
    input  in_valid, in_data, resync,
    output locked, lost, err, err_count, match_count
  );

endinterface

// File: rtl/pseudo_rand_step.sv
// One combinational Galois-style LFSR step: shift left, fold the outgoing
// top bit back in through the polynomial taps.
module pseudo_rand_step #(
  parameter int LFSR_WIDTH = 64
) (
  input  logic [LFSR_WIDTH-1:0] state_i,
  output logic [LFSR_WIDTH-1:0] next_o
);
  import pseudo_rand_pkg::*;

  localparam logic [256:0]          POLY_FULL = lfsr_poly(LFSR_WIDTH);
  localparam logic [LFSR_WIDTH-1:0] POLY      = POLY_FULL[LFSR_WIDTH-1:0];

  logic fb;
  assign fb = state_i[LFSR_WIDTH-1];

  assign next_o[0] = fb & POLY[0];

  generate
    for (genvar gi = 1; gi < LFSR_WIDTH; gi++) begin : g_bit
      assign next_o[gi] = state_i[gi-1] ^ (fb & POLY[gi]);
    end
  endgenerate

endmodule

// File: rtl/pseudo_rand_check.sv
// Checker that hunts for, locks onto and tracks a pseudo_rand stream,
// flagging mismatches and sticky loss of lock.
module pseudo_rand_check #(
  parameter int WIDTH    = 32,
  parameter int LOCK_CNT = 8,
  parameter int LOST_CNT = 4
) (
  input  logic                clk,
  input  logic                reset,
  pseudo_rand_check_if.slave  bus
);
  import pseudo_rand_pkg::*;

  localparam int            LW     = lfsr_width(WIDTH);
  localparam logic [LW-1:0] SEED_L = SEED[LW-1:0];
  localparam logic [7:0]    LOCK_N = 8'(LOCK_CNT);
  localparam logic [7:0]    LOST_N = 8'(LOST_CNT);

  state_e        state_q, state_d;
  logic [LW-1:0] exp_q, exp_d, exp_adv;
  logic [7:0]    run_q, run_d;
  logic [7:0]    miss_q, miss_d;
  logic          lost_q, lost_d;
  logic          err_q, err_d;
  logic          locked_q, locked_d;
  logic [15:0]   errc_q, errc_d;
  logic [31:0]   matchc_q, matchc_d;
  logic          sample_match;
  logic [15:0]   errc_inc;
  logic [31:0]   matchc_inc;

  pseudo_rand_step #(
    .LFSR_WIDTH (LW)
  ) u_step (
    .state_i (exp_q),
    .next_o  (exp_adv)
  );

  assign sample_match = (bus.in_data == exp_q[WIDTH-1:0]);
  assign errc_inc     = (errc_q   == 16'hFFFF)      ? errc_q   : errc_q   + 16'd1;
  assign matchc_inc   = (matchc_q == 32'hFFFF_FFFF) ? matchc_q : matchc_q + 32'd1;

  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    run_d    = run_q;
    miss_d   = miss_q;
    lost_d   = lost_q;
    err_d    = 1'b0;
    errc_d   = errc_q;
    matchc_d = matchc_q;

    if (bus.resync) begin
      state_d  = HUNT;
      exp_d    = SEED_L;
      lost_d   = 1'b0;
      run_d    = 8'd0;
      miss_d   = 8'd0;
      errc_d   = 16'd0;
      matchc_d = 32'd0;
    end else if (bus.in_valid) begin
      unique case (state_q)
        HUNT: begin
          // A mismatch here leaves exp at SEED, so nothing to do.
          if (sample_match) begin
            exp_d   = exp_adv;
            run_d   = 8'd1;
            state_d = (LOCK_N == 8'd1) ? LOCKED : LOCKING;
          end
        end
        LOCKING: begin
          if (sample_match) begin
            exp_d    = exp_adv;
            run_d    = run_q + 8'd1;
            matchc_d = matchc_inc;
            if (run_q + 8'd1 == LOCK_N) begin
              state_d = LOCKED;
            end
          end else begin
            exp_d   = SEED_L;
            run_d   = 8'd0;
            state_d = HUNT;
          end
        end
        LOCKED: begin
          exp_d = exp_adv;
          if (sample_match) begin
            miss_d   = 8'd0;
            matchc_d = matchc_inc;
          end else begin
            err_d  = 1'b1;
            errc_d = errc_inc;
            if (miss_q + 8'd1 == LOST_N) begin
              lost_d  = 1'b1;
              state_d = HUNT;
              exp_d   = SEED_L;
              miss_d  = 8'd0;
              run_d   = 8'd0;
            end else begin
              miss_d = miss_q + 8'd1;
            end
          end
        end
        default: begin
          state_d = HUNT;
          exp_d   = SEED_L;
          run_d   = 8'd0;
          miss_d  = 8'd0;
        end
      endcase
    end
  end

  assign locked_d = (state_d == LOCKED);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= HUNT;
      exp_q    <= SEED_L;
      run_q    <= 8'd0;
      miss_q   <= 8'd0;
      lost_q   <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
      errc_q   <= 16'd0;
      matchc_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      run_q    <= run_d;
      miss_q   <= miss_d;
      lost_q   <= lost_d;
      err_q    <= err_d;
      locked_q <= locked_d;
      errc_q   <= errc_d;
      matchc_q <= matchc_d;
    end
  end

  assign bus.locked      = locked_q;
  assign bus.lost        = lost_q;
  assign bus.err         = err_q;
  assign bus.err_count   = errc_q;
  assign bus.match_count = matchc_q;

endmodule
